// File: rtl/accu_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accu_pkg
//  Description : Shared types, default widths and helper function for the
//                round-robin frame accumulator scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package accu_pkg;

    // Scheduler states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int C_DATA_W = 8;
    localparam int C_SUM_W  = 10;

    // Ceiling log2; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accu_frame_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : accu_frame_sched_if
//  Description : Requester beat bus and result bus of the frame accumulator
//                scheduler. res_partial exists only when
//                ACCU_FRAME_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface accu_frame_sched_if
    import accu_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = C_DATA_W,
    parameter int SUM_W  = C_SUM_W,
    parameter int ID_W   = clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [SUM_W-1:0]        res_data;
    logic [ID_W-1:0]         res_id;
    logic                    busy;
`ifdef ACCU_FRAME_TIMEOUT_EN
    logic                    res_partial;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy, res_partial
    );
    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, busy, res_partial
    );
`else
    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );
    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/accu_frame_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search: returns the first asserted
//                request at or after the pointer, wrapping modulo N_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import accu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_req
);
    int w_best;
    int w_dist;

    // Pick the requester with the smallest wrapped distance from the pointer.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        w_best  = N_REQ;
        w_dist  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = i - int'(ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N_REQ;
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                grant   = ID_W'(i);
                any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/accu_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : accu_frame_sched
//  Description : Round-robin scheduler sharing one frame accumulator between
//                N_REQ requesters; emits the frame sum tagged with its
//                requester id. Optional idle timeout with partial-frame
//                results is enabled by defining ACCU_FRAME_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module accu_frame_sched
    import accu_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = C_DATA_W,
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = C_SUM_W,
    parameter int ID_W      = clog2(N_REQ)
`ifdef ACCU_FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    accu_frame_sched_if.slave    bus
);
    localparam int CNT_W  = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);

    state_t              r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [SUM_W-1:0]    r_sum;
    logic [SUM_W-1:0]    r_res_data;
    logic [ID_W-1:0]     r_res_id;
    logic                r_res_valid;

    logic [ID_W-1:0]     w_arb_grant;
    logic                w_any_req;
    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic [N_REQ-1:0]    w_req_ready;
    logic                w_beat;
    logic                w_last;
    logic [SUM_W-1:0]    w_sum_next;
    logic [ID_W-1:0]     w_ptr_next;

`ifdef ACCU_FRAME_TIMEOUT_EN
    localparam int IDLE_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]   r_idle;
    logic                r_res_partial;
    assign bus.res_partial = r_res_partial;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (r_ptr),
        .grant   (w_arb_grant),
        .any_req (w_any_req)
    );

    // Select the granted requester's valid/data and drive its ready while accumulating.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_valid    = bus.req_valid[i];
                w_sel_data     = bus.req_data[i*DATA_W +: DATA_W];
                w_req_ready[i] = (r_state == ACCUM);
            end
        end
    end

    assign w_beat     = (r_state == ACCUM) && w_sel_valid;
    assign w_last     = (r_count == CNT_W'(FRAME_LEN - 1));
    assign w_sum_next = r_sum + SUM_W'(w_sel_data);
    assign w_ptr_next = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;
    assign bus.busy      = (r_state != IDLE);

    // Scheduler FSM: arbitrate, accumulate one frame, hold the result until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
`ifdef ACCU_FRAME_TIMEOUT_EN
            r_idle        <= '0;
            r_res_partial <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_arb_grant;
                        r_sum   <= '0;
                        r_count <= '0;
                        r_state <= ACCUM;
`ifdef ACCU_FRAME_TIMEOUT_EN
                        r_idle  <= '0;
`endif
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_sum   <= w_sum_next;
                        r_count <= r_count + 1'b1;
`ifdef ACCU_FRAME_TIMEOUT_EN
                        r_idle  <= '0;
`endif
                        if (w_last) begin
                            r_res_data  <= w_sum_next;
                            r_res_id    <= r_grant;
                            r_res_valid <= 1'b1;
                            r_state     <= EMIT;
`ifdef ACCU_FRAME_TIMEOUT_EN
                            r_res_partial <= 1'b0;
`endif
                        end
                    end
`ifdef ACCU_FRAME_TIMEOUT_EN
                    // Stalled for TIMEOUT consecutive cycles: flush what we have, or drop an empty grant.
                    else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
                        r_idle <= '0;
                        if (r_count != '0) begin
                            r_res_data    <= r_sum;
                            r_res_id      <= r_grant;
                            r_res_valid   <= 1'b1;
                            r_res_partial <= 1'b1;
                            r_state       <= EMIT;
                        end else begin
                            r_ptr   <= w_ptr_next;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
`endif
                end
                EMIT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accu_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accu_frame_sched
//  Description : Self-checking bench for accu_frame_sched: directed scenarios
//                followed by randomized traffic, compared every cycle against
//                a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accu_frame_sched;
    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 4;
    localparam int SUM_W     = 10;
    localparam int ID_W      = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accu_frame_sched_if #(
        .N_REQ (N_REQ), .DATA_W (DATA_W), .SUM_W (SUM_W), .ID_W (ID_W)
    ) bus ();

    accu_frame_sched #(
        .N_REQ (N_REQ), .DATA_W (DATA_W), .FRAME_LEN (FRAME_LEN),
        .SUM_W (SUM_W), .ID_W (ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Source side: per-requester pending beats and enables.
    int               src_q[N_REQ][$];
    logic [N_REQ-1:0] en;
    logic             rr;
    bit               refill;

    // Reference model: 0 idle, 1 collecting a frame, 2 offering a result.
    int m_mode, m_grant, m_ptr, m_res_data, m_res_id;
    int m_beats[$];

    // Observed result of the most recent handshake.
    bit got;
    int last_data, last_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_grant = 0; m_ptr = 0; m_res_data = 0; m_res_id = 0;
        m_beats.delete();
    endtask

    // One clock: drive sources, compare outputs with the model, advance both.
    task automatic cycle();
        logic [N_REQ-1:0] v;
        logic [N_REQ-1:0] exp_rdy;
        int s;
        for (int i = 0; i < N_REQ; i++) begin
            if (refill && src_q[i].size() < FRAME_LEN) src_q[i].push_back($urandom_range(0, 255));
            v[i] = en[i] && (src_q[i].size() > 0);
            bus.req_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? DATA_W'(src_q[i][0]) : '0;
        end
        bus.req_valid = v;
        bus.res_ready = rr;
        #1;
        exp_rdy = (m_mode == 1) ? (N_REQ'(1) << m_grant) : '0;
        check("busy",      bus.busy,      (m_mode != 0));
        check("req_ready", bus.req_ready, exp_rdy);
        check("res_valid", bus.res_valid, (m_mode == 2));
        check("res_data",  bus.res_data,  m_res_data);
        check("res_id",    bus.res_id,    m_res_id);
        got = (bus.res_valid === 1'b1) && rr;
        if (got) begin
            last_data = bus.res_data;
            last_id   = bus.res_id;
        end
        case (m_mode)
            0: if (v != '0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N_REQ;
                    if (v[idx]) begin m_grant = idx; break; end
                end
                m_beats.delete();
                m_mode = 1;
            end
            1: if (v[m_grant]) begin
                m_beats.push_back(src_q[m_grant][0]);
                if (m_beats.size() == FRAME_LEN) begin
                    s = 0;
                    foreach (m_beats[j]) s += m_beats[j];
                    m_res_data = s % (1 << SUM_W);
                    m_res_id   = m_grant;
                    m_mode     = 2;
                end
            end
            default: if (rr) begin
                m_ptr  = (m_grant + 1) % N_REQ;
                m_mode = 0;
            end
        endcase
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i] && bus.req_ready[i] === 1'b1) void'(src_q[i].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_result(input string tag, input int budget);
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) cycle();
        check({tag, "_seen"}, got, 1'b1);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_busy",      bus.busy,      0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data",  bus.res_data,  0);
        check("rst_res_id",    bus.res_id,    0);
        model_reset();
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        en = '0; refill = 1'b0; rr = 1'b0;
        bus.req_valid = '0; bus.res_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = '0; rr = 1'b0; refill = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.res_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single requester 0: 10+20+30+40.
        src_q[0] = '{10, 20, 30, 40};
        en = 4'b0001; rr = 1'b1;
        run_result("t1", 20);
        check("t1_data", last_data, 100);
        check("t1_id",   last_id,   0);

        // Requesters 0 and 2 continuously valid: ids alternate.
        do_reset();
        refill = 1'b1; en = 4'b0101; rr = 1'b1;
        for (int f = 0; f < 4; f++) begin
            run_result("t2", 20);
            check("t2_id", last_id, (f % 2 == 0) ? 0 : 2);
        end

        // Full-scale beats on requester 1.
        do_reset();
        src_q[1] = '{255, 255, 255, 255};
        en = 4'b0010; rr = 1'b1;
        run_result("t3", 20);
        check("t3_data", last_data, 1020);
        check("t3_id",   last_id,   1);

        // Back-pressure: result held 5 cycles; next frame waits for the handshake.
        do_reset();
        src_q[3] = '{11, 22, 33, 44, 5, 6, 7, 8};
        en = 4'b1000; rr = 1'b0;
        for (int n = 0; n < 20 && bus.res_valid !== 1'b1; n++) cycle();
        check("t4_wait", bus.res_valid, 1);
        repeat (5) cycle();
        rr = 1'b1;
        run_result("t4a", 4);
        check("t4a_data", last_data, 110);
        run_result("t4b", 20);
        check("t4b_data", last_data, 26);
        check("t4b_id",   last_id,   3);

        // Granted requester stalls mid-frame while another requester waits.
        do_reset();
        src_q[0] = '{1, 2, 3, 4};
        src_q[1] = '{99, 99, 99, 99};
        en = 4'b0001; rr = 1'b1;
        repeat (3) cycle();
        en = 4'b0010;
        repeat (3) cycle();
        en = 4'b0011;
        run_result("t5", 20);
        check("t5_data", last_data, 10);
        check("t5_id",   last_id,   0);

        // Reset after two beats; next frame starts fresh from requester 0.
        do_reset();
        src_q[2] = '{5, 6, 7, 8};
        en = 4'b0100; rr = 1'b1;
        repeat (3) cycle();
        do_reset();
        src_q[0] = '{1, 1, 1, 1};
        src_q[2] = '{2, 2, 2, 2};
        en = 4'b0101; rr = 1'b1;
        run_result("t6", 20);
        check("t6_data", last_data, 4);
        check("t6_id",   last_id,   0);

        // Randomized traffic and back-pressure.
        do_reset();
        refill = 1'b1;
        for (int n = 0; n < 600; n++) begin
            en = N_REQ'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
